// File: rtl/pcie_us_msi_ctrl_if.sv
// pcie_us_msi_ctrl_if
//   Bundle of the UltraScale PCIe hard-IP cfg_interrupt_msi_* signals.
//   master : the MSI controller side (drives int/pending status/constants,
//            receives enable/mme/mask/sent/fail).
//   slave  : the PCIe IP side (mirror image of master).
interface pcie_us_msi_ctrl_if;
  logic [3:0]  cfg_interrupt_msi_enable;
  logic [11:0] cfg_interrupt_msi_mmenable;
  logic        cfg_interrupt_msi_mask_update;
  logic [31:0] cfg_interrupt_msi_data;
  logic [3:0]  cfg_interrupt_msi_select;
  logic [31:0] cfg_interrupt_msi_int;
  logic [31:0] cfg_interrupt_msi_pending_status;
  logic        cfg_interrupt_msi_pending_status_data_enable;
  logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
  logic        cfg_interrupt_msi_sent;
  logic        cfg_interrupt_msi_fail;
  logic [2:0]  cfg_interrupt_msi_attr;
  logic        cfg_interrupt_msi_tph_present;
  logic [1:0]  cfg_interrupt_msi_tph_type;
  logic [8:0]  cfg_interrupt_msi_tph_st_tag;
  logic [3:0]  cfg_interrupt_msi_function_number;

  modport master (
    input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_select, cfg_interrupt_msi_int,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );

  modport slave (
    output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_select, cfg_interrupt_msi_int,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );
endinterface

// File: rtl/pcie_us_msi_ctrl.sv
// pcie_us_msi_ctrl
//   MSI interrupt controller for the UltraScale PCIe hard IP. Latches rising
//   edges of per-vector requests, arbitrates round-robin among eligible
//   pending vectors and issues one MSI at a time, retrying on fail/timeout.
// Ports:
//   clk        PCIe user clock
//   rst        synchronous active-high reset
//   msi_irq_i  per-vector request levels (rising edge = one request)
//   busy_o     high while an MSI is in SEND or WAIT
//   msi        cfg_interrupt_msi_* bundle (master modport)
// Optional build macro:
//   PCIE_US_MSI_MASK_EN  honour the PF0 mask register (cfg_interrupt_msi_data)
//                        and strobe pending status on mask_update.
module pcie_us_msi_ctrl #(
  parameter int MSI_COUNT     = 32,
  parameter int TIMEOUT_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MSI_COUNT-1:0]  msi_irq_i,
  output logic                  busy_o,
  pcie_us_msi_ctrl_if.master    msi
);
  localparam int PW = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;
  // Last WAIT value before the watchdog reaches all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
    {TIMEOUT_WIDTH{1'b1}} - TIMEOUT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                   state_q;
  logic [MSI_COUNT-1:0]     irq_q, pend_q, pend_d, elig, mask_w;
  logic [PW-1:0]            rr_q, gnt_q, sel, rr_nxt;
  logic [TIMEOUT_WIDTH-1:0] wd_q;
  logic [31:0]              int_q, stat_q;
  logic                     de_q, found, go, retry, done, strobe_w;

`ifdef PCIE_US_MSI_MASK_EN
  assign mask_w   = msi.cfg_interrupt_msi_data[MSI_COUNT-1:0];
  assign strobe_w = msi.cfg_interrupt_msi_mask_update;
`else
  assign mask_w   = '0;
  assign strobe_w = 1'b0;
`endif

  logic unused_w;
  assign unused_w = ^{msi.cfg_interrupt_msi_enable[3:1],
                      msi.cfg_interrupt_msi_mmenable[11:3],
                      msi.cfg_interrupt_msi_data,
                      msi.cfg_interrupt_msi_mask_update};

  // Eligible = pending, inside the granted vector range, and not masked.
  always_comb begin
    elig = '0;
    for (int i = 0; i < MSI_COUNT; i++)
      elig[i] = pend_q[i] && !mask_w[i] &&
                (i < (1 << msi.cfg_interrupt_msi_mmenable[2:0]));
  end

  // First eligible index at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < MSI_COUNT; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= MSI_COUNT) idx = idx - MSI_COUNT;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign rr_nxt = (int'(sel) == MSI_COUNT - 1) ? '0 : sel + PW'(1);
  assign go     = (state_q == IDLE) && msi.cfg_interrupt_msi_enable[0] && found;
  // fail beats sent; a timeout only counts when sent did not arrive.
  assign retry  = (state_q == WAIT) &&
                  (msi.cfg_interrupt_msi_fail ||
                   (!msi.cfg_interrupt_msi_sent && wd_q == WD_LAST));
  assign done   = (state_q == WAIT) &&
                  (msi.cfg_interrupt_msi_sent || msi.cfg_interrupt_msi_fail ||
                   wd_q == WD_LAST);

  // New edges OR with a retry re-set; a grant clears its own bit.
  always_comb begin
    pend_d = pend_q | (msi_irq_i & ~irq_q);
    if (go)    pend_d[sel]   = 1'b0;
    if (retry) pend_d[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      wd_q    <= '0;
      int_q   <= '0;
      stat_q  <= '0;
      de_q    <= 1'b0;
    end else begin
      irq_q  <= msi_irq_i;
      pend_q <= pend_d;
      stat_q <= 32'(pend_q);
      de_q   <= (32'(pend_q) != stat_q) || strobe_w;
      int_q  <= '0;
      case (state_q)
        IDLE: if (go) begin
          gnt_q   <= sel;
          rr_q    <= rr_nxt;
          int_q   <= 32'd1 << sel;
          state_q <= SEND;
        end
        SEND: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wd_q <= wd_q + TIMEOUT_WIDTH'(1);
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o                                        = (state_q != IDLE);
  assign msi.cfg_interrupt_msi_int                     = int_q;
  assign msi.cfg_interrupt_msi_pending_status          = stat_q;
  assign msi.cfg_interrupt_msi_pending_status_data_enable = de_q;
  assign msi.cfg_interrupt_msi_select                  = 4'd0;
  assign msi.cfg_interrupt_msi_pending_status_function_num = 4'd0;
  assign msi.cfg_interrupt_msi_attr                    = 3'd0;
  assign msi.cfg_interrupt_msi_tph_present             = 1'b0;
  assign msi.cfg_interrupt_msi_tph_type                = 2'd0;
  assign msi.cfg_interrupt_msi_tph_st_tag              = 9'd0;
  assign msi.cfg_interrupt_msi_function_number         = 4'd0;
endmodule

// File: tb/tb_pcie_us_msi_ctrl.sv
module tb_pcie_us_msi_ctrl;
  localparam int N  = 32;
  localparam int TW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic         busy;

  pcie_us_msi_ctrl_if bus();

  pcie_us_msi_ctrl #(.MSI_COUNT(N), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .msi_irq_i(irq), .busy_o(busy), .msi(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending vectors and the round-robin start point.
  logic [31:0] m_pend;
  int          m_rr;

  function automatic int m_next(input logic [2:0] mme);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (m_pend[idx] && idx < (1 << mme)) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq = '0;
    bus.cfg_interrupt_msi_sent = 1'b0;
    bus.cfg_interrupt_msi_fail = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    m_pend = '0;
    m_rr   = 0;
  endtask

  task automatic wait_int(input int budget, output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (bus.cfg_interrupt_msi_int == 32'd0 && gap < budget);
  endtask

  // Called at the sample where int is visible; answers in WAIT after dly cycles.
  task automatic respond(input int dly, input logic s, input logic f);
    tick();
    repeat (dly) tick();
    bus.cfg_interrupt_msi_sent = s;
    bus.cfg_interrupt_msi_fail = f;
    tick();
    bus.cfg_interrupt_msi_sent = 1'b0;
    bus.cfg_interrupt_msi_fail = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] req);
    irq = req;
    tick();
    irq = '0;
  endtask

  task automatic expect_quiet(input int k, input string name);
    logic [31:0] seen;
    seen = '0;
    repeat (k) begin
      tick();
      seen |= bus.cfg_interrupt_msi_int;
    end
    checks++;
    if (seen !== 32'd0) begin
      errors++;
      $display("FAIL %s: int seen=%h, required none", name, seen);
    end
  endtask

  task automatic check_int(input string name, input logic [31:0] exp_int, input int gap,
                           input int exp_gap);
    checks++;
    if (bus.cfg_interrupt_msi_int !== exp_int || gap != exp_gap) begin
      errors++;
      $display("FAIL %s: int=%h after %0d cycles, required %h after %0d",
               name, bus.cfg_interrupt_msi_int, gap, exp_int, exp_gap);
    end
  endtask

  // Pulse a request set and drain every eligible vector, checking order against the model.
  task automatic run_burst(input logic [31:0] req, input bit rnd_fail);
    int ex, gap, guard;
    bit f, both;
    pulse(req);
    m_pend |= req;
    guard = 0;
    ex = m_next(3'd5);
    while (ex >= 0 && guard < 100) begin
      guard++;
      wait_int(40, gap);
      checks++;
      if (bus.cfg_interrupt_msi_int !== (32'd1 << ex) || gap != 1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL burst_grant: int=%h gap=%0d busy=%b, required int=%h gap=1 busy=1",
                 bus.cfg_interrupt_msi_int, gap, busy, 32'd1 << ex);
        break;
      end
      m_rr = (ex + 1) % N;
      f    = rnd_fail && ($urandom_range(0, 3) == 0);
      both = f && ($urandom_range(0, 1) == 1);
      if (!f) m_pend[ex] = 1'b0;
      respond($urandom_range(0, 3), !f || both, f);
      ex = m_next(3'd5);
    end
    expect_quiet(10, "burst_drained");
    checks++;
    if (bus.cfg_interrupt_msi_pending_status !== m_pend) begin
      errors++;
      $display("FAIL burst_status: status=%h, required %h",
               bus.cfg_interrupt_msi_pending_status, m_pend);
    end
  endtask

  task automatic test_reset();
    irq = '1;
    bus.cfg_interrupt_msi_enable      = 4'h1;
    bus.cfg_interrupt_msi_mmenable    = 12'd5;
    bus.cfg_interrupt_msi_mask_update = 1'b0;
    bus.cfg_interrupt_msi_data        = '0;
    do_reset();
    checks++;
    if ({bus.cfg_interrupt_msi_int, bus.cfg_interrupt_msi_pending_status,
         bus.cfg_interrupt_msi_pending_status_data_enable, busy,
         bus.cfg_interrupt_msi_select, bus.cfg_interrupt_msi_pending_status_function_num,
         bus.cfg_interrupt_msi_attr, bus.cfg_interrupt_msi_tph_present,
         bus.cfg_interrupt_msi_tph_type, bus.cfg_interrupt_msi_tph_st_tag,
         bus.cfg_interrupt_msi_function_number} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: int=%h status=%h de=%b busy=%b, required all zero",
               bus.cfg_interrupt_msi_int, bus.cfg_interrupt_msi_pending_status,
               bus.cfg_interrupt_msi_pending_status_data_enable, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    irq = 32'h8;
    tick();                       // edge sampled, pending set
    irq = '0;
    checks++;
    if (bus.cfg_interrupt_msi_int !== 32'd0) begin
      errors++;
      $display("FAIL single_early: int=%h, required 0", bus.cfg_interrupt_msi_int);
    end
    tick();
    checks++;
    if (bus.cfg_interrupt_msi_int !== 32'h8 || bus.cfg_interrupt_msi_pending_status !== 32'h8 ||
        busy !== 1'b1 || bus.cfg_interrupt_msi_pending_status_data_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_int: int=%h status=%h busy=%b de=%b, required 8 8 1 1",
               bus.cfg_interrupt_msi_int, bus.cfg_interrupt_msi_pending_status, busy,
               bus.cfg_interrupt_msi_pending_status_data_enable);
    end
    tick();
    checks++;
    if (bus.cfg_interrupt_msi_int !== 32'd0 || bus.cfg_interrupt_msi_pending_status !== 32'd0) begin
      errors++;
      $display("FAIL single_one_cycle: int=%h status=%h, required 0 0",
               bus.cfg_interrupt_msi_int, bus.cfg_interrupt_msi_pending_status);
    end
    bus.cfg_interrupt_msi_sent = 1'b1;
    tick();
    bus.cfg_interrupt_msi_sent = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.cfg_interrupt_msi_pending_status_data_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%b de=%b, required 0 0", busy,
               bus.cfg_interrupt_msi_pending_status_data_enable);
    end
    expect_quiet(10, "single_no_repeat");
  endtask

  task automatic test_round_robin();
    do_reset();
    run_burst(32'h23, 1'b0);      // 0, 1, 5
    run_burst(32'h84, 1'b0);      // rr=6: 7 then 2
  endtask

  task automatic test_fail_retry();
    int gap;
    do_reset();
    pulse(32'h10);
    wait_int(10, gap);
    check_int("retry_first", 32'h10, gap, 1);
    respond(1, 1'b0, 1'b1);
    wait_int(10, gap);
    check_int("retry_second", 32'h10, gap, 1);
    respond(0, 1'b1, 1'b1);       // sent+fail together counts as fail
    wait_int(10, gap);
    check_int("retry_both", 32'h10, gap, 1);
    respond(2, 1'b1, 1'b0);
    expect_quiet(20, "retry_done");
    checks++;
    if (bus.cfg_interrupt_msi_pending_status !== 32'd0) begin
      errors++;
      $display("FAIL retry_status: status=%h, required 0", bus.cfg_interrupt_msi_pending_status);
    end
  endtask

  task automatic test_timeout();
    int gap;
    do_reset();
    pulse(32'h2);
    wait_int(10, gap);
    check_int("timeout_first", 32'h2, gap, 1);
    // SEND + 15 WAIT + IDLE before the re-issue
    wait_int(40, gap);
    check_int("timeout_reissue1", 32'h2, gap, (1 << TW) + 1);
    wait_int(40, gap);
    check_int("timeout_reissue2", 32'h2, gap, (1 << TW) + 1);
    respond(0, 1'b1, 1'b0);
    expect_quiet(25, "timeout_done");
  endtask

  task automatic test_gating();
    int gap;
    do_reset();
    bus.cfg_interrupt_msi_mmenable = 12'd1;
    pulse(32'h4);
    expect_quiet(10, "mme_blocked");
    checks++;
    if (bus.cfg_interrupt_msi_pending_status !== 32'h4) begin
      errors++;
      $display("FAIL mme_pending: status=%h, required 4", bus.cfg_interrupt_msi_pending_status);
    end
    bus.cfg_interrupt_msi_mmenable = 12'd2;
    wait_int(10, gap);
    check_int("mme_release", 32'h4, gap, 1);
    respond(0, 1'b1, 1'b0);
    bus.cfg_interrupt_msi_mmenable = 12'd5;
    bus.cfg_interrupt_msi_enable   = 4'h0;
    pulse(32'h1);
    expect_quiet(10, "enable_blocked");
    checks++;
    if (bus.cfg_interrupt_msi_pending_status !== 32'h1) begin
      errors++;
      $display("FAIL enable_pending: status=%h, required 1", bus.cfg_interrupt_msi_pending_status);
    end
    bus.cfg_interrupt_msi_enable = 4'h1;
    wait_int(10, gap);
    check_int("enable_release", 32'h1, gap, 1);
    respond(0, 1'b1, 1'b0);
    expect_quiet(10, "enable_done");
  endtask

  task automatic test_coalesce();
    int gap;
    do_reset();
    bus.cfg_interrupt_msi_enable = 4'h0;
    pulse(32'h40);
    tick();
    pulse(32'h40);
    tick();
    bus.cfg_interrupt_msi_enable = 4'h1;
    wait_int(10, gap);
    check_int("coalesce_one", 32'h40, gap, 1);
    respond(0, 1'b1, 1'b0);
    expect_quiet(20, "coalesce_single");
  endtask

  task automatic test_inflight_edge();
    int gap;
    do_reset();
    pulse(32'h200);
    wait_int(10, gap);
    check_int("inflight_first", 32'h200, gap, 1);
    tick();                       // WAIT
    pulse(32'h200);               // new edge on the in-flight vector
    bus.cfg_interrupt_msi_sent = 1'b1;
    tick();
    bus.cfg_interrupt_msi_sent = 1'b0;
    wait_int(10, gap);
    check_int("inflight_second", 32'h200, gap, 1);
    respond(0, 1'b1, 1'b0);
    expect_quiet(15, "inflight_done");
  endtask

  task automatic test_mid_reset();
    int gap;
    do_reset();
    pulse(32'h8);
    wait_int(10, gap);
    check_int("midrst_int", 32'h8, gap, 1);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.cfg_interrupt_msi_int !== 32'd0 || bus.cfg_interrupt_msi_pending_status !== 32'd0 ||
        bus.cfg_interrupt_msi_pending_status_data_enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: int=%h status=%h de=%b busy=%b, required all zero",
               bus.cfg_interrupt_msi_int, bus.cfg_interrupt_msi_pending_status,
               bus.cfg_interrupt_msi_pending_status_data_enable, busy);
    end
    rst = 1'b0;
    m_pend = '0;
    m_rr   = 0;
    expect_quiet(30, "midrst_no_retry");
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 8; r++)
      run_burst($urandom, 1'b1);
  endtask

`ifdef PCIE_US_MSI_MASK_EN
  task automatic test_mask();
    do_reset();
    bus.cfg_interrupt_msi_data = 32'h1;
    pulse(32'h1);
    expect_quiet(10, "mask_blocked");
    bus.cfg_interrupt_msi_data        = 32'h0;
    bus.cfg_interrupt_msi_mask_update = 1'b1;
    tick();
    bus.cfg_interrupt_msi_mask_update = 1'b0;
    checks++;
    if (bus.cfg_interrupt_msi_pending_status_data_enable !== 1'b1 ||
        bus.cfg_interrupt_msi_int !== 32'h1) begin
      errors++;
      $display("FAIL mask_update: de=%b int=%h, required 1 1",
               bus.cfg_interrupt_msi_pending_status_data_enable, bus.cfg_interrupt_msi_int);
    end
    respond(0, 1'b1, 1'b0);
    expect_quiet(10, "mask_done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fail_retry();
    test_timeout();
    test_gating();
    test_coalesce();
    test_inflight_edge();
    test_mid_reset();
`ifdef PCIE_US_MSI_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_us_msi_ctrl.md
Name: pcie_us_msi_ctrl

Overview:
MSI interrupt controller that drives the MSI interface of the UltraScale PCIe hard IP on behalf of the core logic. Latches per-vector request pulses from the core and arbitrates among them round-robin. Issues one MSI at a time through the cfg_interrupt_msi_int/sent/fail handshake, retrying vectors that fail or time out. Sits directly on the IP cfg_interrupt_msi_* ports, between the IP and the core interrupt sources, on the PCIe user clock.

Parameters:
MSI_COUNT, 32, number of request inputs/vectors (1..32)
TIMEOUT_WIDTH, 10, width of the handshake watchdog counter; timeout = 2^TIMEOUT_WIDTH-1 cycles

Ports:
clk  input  1  PCIe user clock (250 MHz)
rst  input  1  synchronous, active-high reset
msi_irq  input  MSI_COUNT  per-vector request; level high for one or more cycles = one request
cfg_interrupt_msi_enable  input  4  bit 0 = MSI enabled for PF0
cfg_interrupt_msi_mmenable  input  12  bits [2:0] = PF0 multiple-message-enable (log2 vectors granted)
cfg_interrupt_msi_mask_update  input  1  mask register changed (used only with the optional feature)
cfg_interrupt_msi_data  input  32  PF0 MSI mask register (select tied to 0)
cfg_interrupt_msi_select  output  4  constant 0
cfg_interrupt_msi_int  output  32  one-hot, one-cycle MSI request
cfg_interrupt_msi_pending_status  output  32  pending vector bitmap
cfg_interrupt_msi_pending_status_data_enable  output  1  one-cycle strobe on pending-bitmap change
cfg_interrupt_msi_pending_status_function_num  output  4  constant 0
cfg_interrupt_msi_sent  input  1  IP accepted and sent the MSI
cfg_interrupt_msi_fail  input  1  IP failed to send the MSI
cfg_interrupt_msi_attr  output  3  constant 0
cfg_interrupt_msi_tph_present  output  1  constant 0
cfg_interrupt_msi_tph_type  output  2  constant 0
cfg_interrupt_msi_tph_st_tag  output  9  constant 0
cfg_interrupt_msi_function_number  output  4  constant 0
busy  output  1  high in SEND or WAIT

Behaviour:
- Reset: pending=0, rr_ptr=0, state=IDLE, watchdog=0; all outputs 0.
- Pending: rising edge of msi_irq[i] (registered previous value) sets pending[i] the next cycle. Multiple edges while pending coalesce into one MSI. Bits >= MSI_COUNT are always 0.
- Eligible vector: pending[i] AND i < 2^mmenable[2:0]. Ineligible vectors stay pending and are never dropped.
- IDLE:
  - If enable[0]=1 and any vector is eligible, grant the first eligible index at or after rr_ptr, wrapping modulo MSI_COUNT.
  - Clear pending[grant], set rr_ptr=grant+1 (wraps to 0 at MSI_COUNT), go to SEND.
- SEND (1 cycle): cfg_interrupt_msi_int = 1<<grant. Watchdog is cleared. Go to WAIT.
- WAIT: int=0; watchdog increments each cycle.
  - sent: go to IDLE.
  - fail, or watchdog reaches all-ones: set pending[grant] again, go to IDLE.
  - sent and fail together: treat as fail.
- Latency: msi_irq edge at cycle N -> pending at N+1 -> int at N+2 (IDLE, enabled). Back-to-back MSIs are at least 3 cycles apart (SEND, WAIT>=1, IDLE).
- Simultaneous events: a fail re-set and a new edge on the same bit OR together. A new edge on the in-flight vector during WAIT sets pending, producing a second MSI after completion.
- enable[0] drop: no new grants; any in-flight WAIT still completes or times out normally; pending is retained.
- Reset mid-operation: the in-flight vector is dropped without retry; all pending requests are lost.
- Pending status: cfg_interrupt_msi_pending_status = zero-extended pending, registered. data_enable pulses for one cycle, the cycle after any change of that register.

Optional Feature:
PCIE_US_MSI_MASK_EN
- Defined:
  - Eligibility additionally requires cfg_interrupt_msi_data[i]=0.
  - Masked vectors remain pending.
  - On mask_update, the mask is re-sampled and data_enable is strobed once (even without a pending change) so the IP sees current pending bits.
- Undefined: cfg_interrupt_msi_data and mask_update are ignored; all granted vectors are eligible.

Test Plan:
- Single request: enable=1, mme=5, pulse msi_irq[3] at cycle 10, sent 2 cycles after int -> int=32'h8 exactly at cycle 12 for 1 cycle; pending_status 0x8 then 0x0; busy low after sent.
- Round-robin: msi_irq[0], [1] and [5] rise together, immediate sent each time -> int order 0x1, 0x2, 0x20. Then with rr_ptr=6, vectors 2 and 7 pending -> 0x80 before 0x4.
- Fail retry: pulse [4], first response fail, second sent -> int=0x10 issued twice; pending[4] cleared only after sent.
- Timeout: TIMEOUT_WIDTH=4, pulse [1], never respond -> int=0x2 re-issued after 15 WAIT cycles; repeats until sent.
- mme/enable gating: mme=1, pulse [2] -> no int while pending=0x4; set mme=2 -> int=0x4. enable=0 with [0] pending -> no int until enable=1.
- Mask (macro defined): mask=0x1, pulse [0] -> no int; clear mask plus mask_update -> data_enable strobe and int=0x1. Reset asserted in WAIT -> all outputs 0, no retry.
